// File: rtl/psx_host_poller.sv
// PSX controller-bus initiator: clocks bytes LSB-first out on CMD, samples DAT,
// and waits for the controller ACK between bytes. Buffers are external SRAM-style ports.
module psx_host_poller #(
  parameter int unsigned HALF_BITS        = 4,
  parameter int unsigned ACK_TIMEOUT_BITS = 10,
  parameter int unsigned ADDR_BITS        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] byte_count,
  output logic [ADDR_BITS-1:0] tx_addr,
  input  logic [7:0]           tx_data,
  output logic                 rx_write_en,
  output logic [ADDR_BITS-1:0] rx_addr,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 psx_sel_n,
  output logic                 psx_clk,
  output logic                 psx_cmd,
  input  logic                 psx_dat,
  input  logic                 psx_ack_n
);

  localparam int unsigned TW =
      ((ACK_TIMEOUT_BITS > HALF_BITS + 1) ? ACK_TIMEOUT_BITS : HALF_BITS + 1) + 1;
  localparam logic [TW-1:0] HALF_END = TW'((1 << HALF_BITS) - 1);
  localparam logic [TW-1:0] SEL_END  = TW'((2 << HALF_BITS) - 1);
  localparam logic [TW-1:0] ACK_END  = TW'((1 << ACK_TIMEOUT_BITS) - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StClkLow, StClkHigh, StAckWait, StGap, StDeselect, StDone
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ADDR_BITS-1:0] count_q, index_q;
  logic [2:0]           bit_q;
  logic [7:0]           tx_byte_q, rx_byte_q;
  logic                 ack_seen_q, error_q, rx_we_q;
  logic                 dat_meta_q, dat_sync_q, ack_meta_q, ack_sync_q;

  logic half_end, sel_end, ack_tmo, last_byte, last_bit, ack_ok;

  assign half_end  = (timer_q == HALF_END);
  assign sel_end   = (timer_q == SEL_END);
  assign ack_tmo   = (timer_q == ACK_END);
  assign last_byte = (index_q == count_q - ADDR_BITS'(1));
  assign last_bit  = (bit_q == 3'd7);
  assign ack_ok    = ack_seen_q | ~ack_sync_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; the timebase restarts whenever the state changes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = (byte_count != '0) ? StSelect : StDone;
      StSelect:   if (sel_end) state_d = StClkLow;
      StClkLow:   if (half_end) state_d = StClkHigh;
      StClkHigh: begin
        if (half_end) begin
          if (!last_bit)      state_d = StClkLow;
          else if (last_byte) state_d = StDeselect;
          else                state_d = StAckWait;
        end
      end
      StAckWait: begin
        if (ack_ok)       state_d = StGap;
        else if (ack_tmo) state_d = StDeselect;
      end
      StGap:      if (half_end) state_d = StClkLow;
      StDeselect: if (half_end) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
  end

  // Output logic
  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    psx_sel_n = 1'b0;
    psx_clk   = 1'b1;
    psx_cmd   = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy      = 1'b0;
        psx_sel_n = 1'b1;
      end
      StClkLow: begin
        psx_clk = 1'b0;
        psx_cmd = tx_byte_q[bit_q];
      end
      StClkHigh: psx_cmd = tx_byte_q[bit_q];
      StDone: begin
        done      = 1'b1;
        psx_sel_n = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: synchronisers, byte shifting, index and ACK tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      ack_meta_q <= 1'b1;
      ack_sync_q <= 1'b1;
      count_q    <= '0;
      index_q    <= '0;
      bit_q      <= '0;
      tx_byte_q  <= '0;
      rx_byte_q  <= '0;
      ack_seen_q <= 1'b0;
      error_q    <= 1'b0;
      rx_we_q    <= 1'b0;
    end else begin
      dat_meta_q <= psx_dat;
      dat_sync_q <= dat_meta_q;
      ack_meta_q <= psx_ack_n;
      ack_sync_q <= ack_meta_q;
      rx_we_q    <= (state_q == StClkHigh) && half_end && last_bit;

      if (state_q == StIdle && start) begin
        count_q <= byte_count;
        index_q <= '0;
        error_q <= 1'b0;
      end

      if ((state_q == StSelect && sel_end) || (state_q == StGap && half_end)) begin
        tx_byte_q <= tx_data;
        bit_q     <= '0;
      end

      if (state_q == StClkHigh && half_end) begin
        rx_byte_q[bit_q] <= dat_sync_q;
        if (!last_bit) bit_q <= bit_q + 3'd1;
      end

      // ACKs are honoured from the start of the final high phase of a byte onward
      if (state_q == StClkLow && half_end && last_bit) begin
        ack_seen_q <= 1'b0;
      end else if (((state_q == StClkHigh && last_bit) || state_q == StAckWait) &&
                   !ack_sync_q) begin
        ack_seen_q <= 1'b1;
      end

      if (state_q == StAckWait) begin
        if (ack_ok)       index_q <= index_q + ADDR_BITS'(1);
        else if (ack_tmo) error_q <= 1'b1;
      end
    end
  end

  assign tx_addr     = index_q;
  assign rx_addr     = index_q;
  assign rx_data     = rx_byte_q;
  assign rx_write_en = rx_we_q;
  assign error       = error_q;

endmodule

// File: tb/tb_psx_host_poller.sv
// Directed bench for psx_host_poller with an emulated controller and an rx scoreboard.
module tb_psx_host_poller;

  localparam int unsigned HALF_BITS        = 4;
  localparam int unsigned ACK_TIMEOUT_BITS = 10;
  localparam int unsigned ADDR_BITS        = 5;
  localparam int HALF    = 1 << HALF_BITS;
  localparam int ACK_LIM = 1 << ACK_TIMEOUT_BITS;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           data;
  } rx_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [ADDR_BITS-1:0] byte_count = '0;
  logic [ADDR_BITS-1:0] tx_addr, rx_addr;
  logic [7:0]           tx_data, rx_data;
  logic                 rx_write_en, busy, done, error, psx_sel_n, psx_clk, psx_cmd;
  logic                 psx_dat = 1'b1;
  logic                 psx_ack_n = 1'b1;

  logic [7:0] tx_mem   [32];
  logic [7:0] dev_resp [32];
  logic       dev_ack  [32];
  int         ack_delay = 20;

  int  compared = 0;
  int  mismatched = 0;
  rx_t exp_q[$];
  logic [7:0] cmd_cap[$];
  int  cyc = 0, clk_falls = 0, done_cnt = 0, done_cyc = 0, rx_cnt = 0, rx_last_cyc = 0;
  int  sel_bad = 0;
  event ack_ev;

  assign tx_data = tx_mem[tx_addr];

  psx_host_poller #(
    .HALF_BITS(HALF_BITS), .ACK_TIMEOUT_BITS(ACK_TIMEOUT_BITS), .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .byte_count(byte_count),
    .tx_addr(tx_addr), .tx_data(tx_data), .rx_write_en(rx_write_en), .rx_addr(rx_addr),
    .rx_data(rx_data), .busy(busy), .done(done), .error(error), .psx_sel_n(psx_sel_n),
    .psx_clk(psx_clk), .psx_cmd(psx_cmd), .psx_dat(psx_dat), .psx_ack_n(psx_ack_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Emulated controller: DAT changes on CLK fall, bytes counted on CLK rise
  logic prev_clk = 1'b1, prev_sel = 1'b1;
  int   dev_byte = 0, dev_bit = 0;
  logic [7:0] cmd_sh = '0;
  always begin
    @(psx_clk or psx_sel_n);
    if (psx_sel_n === 1'b0 && prev_sel === 1'b1) begin
      dev_byte = 0;
      dev_bit  = 0;
    end
    if (psx_sel_n === 1'b0 && psx_clk === 1'b0 && prev_clk === 1'b1) begin
      clk_falls++;
      psx_dat = dev_resp[dev_byte & 31][dev_bit];
    end
    if (psx_sel_n === 1'b0 && psx_clk === 1'b1 && prev_clk === 1'b0) begin
      cmd_sh = {psx_cmd, cmd_sh[7:1]};
      dev_bit++;
      if (dev_bit == 8) begin
        dev_bit = 0;
        cmd_cap.push_back(cmd_sh);
        if (dev_ack[dev_byte & 31]) -> ack_ev;
        dev_byte++;
      end
    end
    prev_clk = psx_clk;
    prev_sel = psx_sel_n;
  end

  always begin
    @(ack_ev);
    repeat (ack_delay) @(posedge clk);
    psx_ack_n = 1'b0;
    repeat (4) @(posedge clk);
    psx_ack_n = 1'b1;
  end

  // Output monitor and rx scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy && !done && psx_sel_n) sel_bad++;
      if (rx_write_en) begin
        rx_cnt++;
        rx_last_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("rx_extra", rx_write_en, 1'b0);
        end else begin
          rx_t e;
          e = exp_q.pop_front();
          check("rx_addr", rx_addr, e.addr);
          check("rx_data", rx_data, e.data);
        end
      end
    end
  end

  task automatic run_txn(input int n, input int poke_at, output int cycles);
    @(negedge clk);
    byte_count = ADDR_BITS'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 6000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == poke_at) begin
        byte_count = ADDR_BITS'(7);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b1);
    check("sel_n_at_done", psx_sel_n, 1'b1);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic load3(input logic [7:0] t0, t1, t2, r0, r1, r2);
    tx_mem[0] = t0; tx_mem[1] = t1; tx_mem[2] = t2;
    dev_resp[0] = r0; dev_resp[1] = r1; dev_resp[2] = r2;
  endtask

  initial begin
    int n, f0, d0, c0, s0, r0;
    for (int i = 0; i < 32; i++) begin
      tx_mem[i] = '0;
      dev_resp[i] = 8'hFF;
      dev_ack[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel_n", psx_sel_n, 1'b1);
    check("rst_psx_clk", psx_clk, 1'b1);
    check("rst_psx_cmd", psx_cmd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_rx_we", rx_write_en, 1'b0);
    @(negedge clk) reset = 1'b0;

    // Normal poll
    load3(8'h01, 8'h42, 8'h00, 8'hFF, 8'h41, 8'h5A);
    dev_ack[0] = 1'b1; dev_ack[1] = 1'b1; ack_delay = 20;
    exp_q.push_back('{5'd0, 8'hFF});
    exp_q.push_back('{5'd1, 8'h41});
    exp_q.push_back('{5'd2, 8'h5A});
    f0 = clk_falls; d0 = done_cnt; c0 = cmd_cap.size(); s0 = sel_bad;
    run_txn(3, -1, n);
    check("poll_clk_falls", clk_falls - f0, 24);
    check("poll_done_cnt", done_cnt - d0, 1);
    check("poll_error", error, 1'b0);
    check("poll_rx_left", exp_q.size(), 0);
    check("poll_sel_low", sel_bad - s0, 0);
    for (int k = 0; k < 3; k++) check("poll_cmd_byte", cmd_cap[c0 + k], tx_mem[k]);

    // Bit order, single byte (no ACK wait)
    tx_mem[0] = 8'h80; dev_resp[0] = 8'h01;
    exp_q.push_back('{5'd0, 8'h01});
    f0 = clk_falls; c0 = cmd_cap.size();
    run_txn(1, -1, n);
    check("bit_cmd_lsb_first", cmd_cap[c0], 8'h80);
    check("bit_duration", n, 19 * HALF);
    check("bit_clk_falls", clk_falls - f0, 8);
    check("bit_rx_left", exp_q.size(), 0);

    // ACK timeout on byte 1
    load3(8'hA5, 8'h3C, 8'h0F, 8'h11, 8'h22, 8'h33);
    dev_ack[0] = 1'b1; dev_ack[1] = 1'b0; ack_delay = 20;
    exp_q.push_back('{5'd0, 8'h11});
    exp_q.push_back('{5'd1, 8'h22});
    f0 = clk_falls; r0 = rx_cnt;
    run_txn(3, -1, n);
    check("tmo_error", error, 1'b1);
    check("tmo_rx_count", rx_cnt - r0, 2);
    check("tmo_rx_left", exp_q.size(), 0);
    check("tmo_done_delay", done_cyc - rx_last_cyc, ACK_LIM + HALF);
    check("tmo_clk_falls", clk_falls - f0, 16);
    check("tmo_sel_n", psx_sel_n, 1'b1);

    // Early ACK during final high phase of byte 0
    load3(8'h55, 8'hAA, 8'h00, 8'h0F, 8'hF0, 8'h00);
    dev_ack[0] = 1'b1; dev_ack[1] = 1'b0; ack_delay = 2;
    exp_q.push_back('{5'd0, 8'h0F});
    exp_q.push_back('{5'd1, 8'hF0});
    run_txn(2, -1, n);
    check("early_error", error, 1'b0);
    check("early_fast", n < ACK_LIM, 1'b1);
    check("early_rx_left", exp_q.size(), 0);
    ack_delay = 20;

    // Zero-length start
    f0 = clk_falls; d0 = done_cnt;
    run_txn(0, -1, n);
    check("zero_done_next", n, 0);
    check("zero_no_clk", clk_falls - f0, 0);
    check("zero_done_cnt", done_cnt - d0, 1);

    // Start while busy is ignored
    tx_mem[0] = 8'h3C; dev_resp[0] = 8'hC3;
    exp_q.push_back('{5'd0, 8'hC3});
    f0 = clk_falls; d0 = done_cnt;
    run_txn(1, 50, n);
    repeat (60) @(posedge clk);
    #1;
    check("busy_start_falls", clk_falls - f0, 8);
    check("busy_start_done", done_cnt - d0, 1);
    check("busy_start_idle", busy, 1'b0);
    check("busy_start_rx_left", exp_q.size(), 0);

    // Reset during CLK_LOW of byte 1
    load3(8'h01, 8'h42, 8'h00, 8'hFF, 8'h41, 8'h5A);
    dev_ack[0] = 1'b1; dev_ack[1] = 1'b1;
    exp_q.push_back('{5'd0, 8'hFF});
    exp_q.push_back('{5'd1, 8'h41});
    exp_q.push_back('{5'd2, 8'h5A});
    f0 = clk_falls; d0 = done_cnt;
    @(negedge clk);
    byte_count = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (clk_falls - f0 < 9 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_reached_byte1", clk_falls - f0, 9);
    check("mid_sel_n", psx_sel_n, 1'b1);
    check("mid_psx_clk", psx_clk, 1'b1);
    check("mid_psx_cmd", psx_cmd, 1'b1);
    check("mid_busy", busy, 1'b0);
    check("mid_rx_pending", exp_q.size(), 2);
    exp_q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt - d0, 0);

    exp_q.push_back('{5'd0, 8'hFF});
    exp_q.push_back('{5'd1, 8'h41});
    exp_q.push_back('{5'd2, 8'h5A});
    f0 = clk_falls; c0 = cmd_cap.size();
    run_txn(3, -1, n);
    check("after_rst_falls", clk_falls - f0, 24);
    check("after_rst_error", error, 1'b0);
    check("after_rst_rx_left", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) check("after_rst_cmd", cmd_cap[c0 + k], tx_mem[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
